// File: rtl/audio_voice_mixer.sv
// Multi-voice waveform mixer: VOICES phase accumulators are evaluated one per clock
// through a shared sine-ROM port once per sample tick, and their levels are summed into mix.
module audio_voice_mixer #(
    parameter int BITS    = 6,
    parameter int VOICES  = 4,
    parameter int PHASE_W = 16,
    parameter int DIV     = 64,
    localparam int SEL_W  = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int MIX_W  = BITS + $clog2(VOICES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   voice_sel,
    input  logic [1:0]         cfg_form,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic               cfg_gate,
    input  logic               cfg_phase_rst,
    output logic [9:0]         rom_index,
    input  logic [BITS-1:0]    rom_value,
    output logic [MIX_W-1:0]   mix,
    output logic               mix_valid,
    output logic               busy
);

    localparam int DIV_W = $clog2(DIV);

    localparam logic [1:0] FORM_SIN = 2'd0;
    localparam logic [1:0] FORM_TRI = 2'd1;
    localparam logic [1:0] FORM_SQ  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [SEL_W-1:0]   voice_q, voice_d;
    logic [MIX_W-1:0]   acc_q, acc_d;
    logic [MIX_W-1:0]   mix_q, mix_d;
    logic               mixValid_q, mixValid_d;

    logic [1:0]         shadowForm_q     [VOICES];
    logic [PHASE_W-1:0] shadowInc_q      [VOICES];
    logic               shadowGate_q     [VOICES];
    logic               shadowPhaseRst_q [VOICES];
    logic [1:0]         actForm_q        [VOICES];
    logic [PHASE_W-1:0] actInc_q         [VOICES];
    logic               actGate_q        [VOICES];
    logic               actPhaseRst_q    [VOICES];
    logic [PHASE_W-1:0] phase_q          [VOICES];

    logic [PHASE_W-1:0] phaseNew;
    logic [9:0]         idx;
    logic [8:0]         triVal;
    logic [BITS-1:0]    level;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // The tick copy reads the shadow values from before any same-cycle write, and the
    // write is applied after the phase_rst clear so it survives until the following tick.
    // Selects at or above VOICES match no slot and are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < VOICES; v++) begin
                shadowForm_q[v]     <= '0;
                shadowInc_q[v]      <= '0;
                shadowGate_q[v]     <= 1'b0;
                shadowPhaseRst_q[v] <= 1'b0;
                actForm_q[v]        <= '0;
                actInc_q[v]         <= '0;
                actGate_q[v]        <= 1'b0;
                actPhaseRst_q[v]    <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (tick) begin
                    actForm_q[v]        <= shadowForm_q[v];
                    actInc_q[v]         <= shadowInc_q[v];
                    actGate_q[v]        <= shadowGate_q[v];
                    actPhaseRst_q[v]    <= shadowPhaseRst_q[v];
                    shadowPhaseRst_q[v] <= 1'b0;
                end
                if (cfg_we && (voice_sel == SEL_W'(v))) begin
                    shadowForm_q[v]     <= cfg_form;
                    shadowInc_q[v]      <= cfg_inc;
                    shadowGate_q[v]     <= cfg_gate;
                    shadowPhaseRst_q[v] <= cfg_phase_rst;
                end
            end
        end
    end

    // Evaluate the voice selected by the sequencer; only meaningful while in CALC.
    always_comb begin
        phaseNew = phase_q[voice_q] + actInc_q[voice_q];
        if (!actGate_q[voice_q] || actPhaseRst_q[voice_q]) begin
            phaseNew = '0;
        end
        idx    = phaseNew[PHASE_W-1 -: 10];
        triVal = idx[9] ? ~idx[8:0] : idx[8:0];
        level  = '0;
        if (actGate_q[voice_q]) begin
            case (actForm_q[voice_q])
                FORM_SIN: level = rom_value;
                FORM_TRI: level = BITS'(triVal >> (9 - BITS));
                FORM_SQ:  level = idx[9] ? '0 : '1;
                default:  level = BITS'(idx >> (10 - BITS));
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= '0;
            end
        end else if (state_q == CALC) begin
            phase_q[voice_q] <= phaseNew;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            voice_q    <= '0;
            acc_q      <= '0;
            mix_q      <= '0;
            mixValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            voice_q    <= voice_d;
            acc_q      <= acc_d;
            mix_q      <= mix_d;
            mixValid_q <= mixValid_d;
        end
    end

    // mix is loaded on entry to DONE so the new sum is visible together with mix_valid.
    always_comb begin
        state_d    = state_q;
        voice_d    = voice_q;
        acc_d      = acc_q;
        mix_d      = mix_q;
        mixValid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CALC;
                    voice_d = '0;
                    acc_d   = '0;
                end
            end
            CALC: begin
                acc_d = acc_q + MIX_W'(level);
                if (voice_q == SEL_W'(VOICES - 1)) begin
                    state_d    = DONE;
                    mix_d      = acc_d;
                    mixValid_d = 1'b1;
                end else begin
                    voice_d = voice_q + SEL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_index = (state_q == CALC) ? idx : 10'd0;
    assign mix       = mix_q;
    assign mix_valid = mixValid_q;
    assign busy      = (state_q != IDLE);

endmodule
